// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner: per-digit hex+dp storage, blanking
// gap between digits, and a frame_done pulse each time the scan wraps.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int DIV          = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [2:0]            wr_idx,
  input  logic [4:0]            wr_data,
  input  logic [NUM_DIGITS-1:0] digit_en,
  output logic [7:0]            seg_out,
  output logic [NUM_DIGITS-1:0] an_out,
  output logic                  frame_done
);

  localparam int MAX_CNT = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(MAX_CNT) + 1;
  localparam int PW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  localparam logic [0:0] BLANK = 1'b0;
  localparam logic [0:0] SHOW  = 1'b1;

  logic [0:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic [PW-1:0] ptr_reg;
  logic [4:0]    digit_reg [NUM_DIGITS];

  logic [7:0]            seg_reg;
  logic [NUM_DIGITS-1:0] an_reg;
  logic                  frame_done_reg;

  function automatic logic [7:0] enc(input logic [4:0] d);
    logic [7:0] code;
    case (d[3:0])
      4'h0: code = 8'hFC;  4'h1: code = 8'h60;  4'h2: code = 8'hDA;  4'h3: code = 8'hF2;
      4'h4: code = 8'h66;  4'h5: code = 8'hB6;  4'h6: code = 8'hBE;  4'h7: code = 8'hE0;
      4'h8: code = 8'hFE;  4'h9: code = 8'hF6;  4'hA: code = 8'hEE;  4'hB: code = 8'h3E;
      4'hC: code = 8'h9C;  4'hD: code = 8'h7A;  4'hE: code = 8'h9E;  default: code = 8'h8E;
    endcase
    return code | {7'b0, d[4]};
  endfunction

  // Digit storage; writes to indices beyond the bank are dropped.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      always_ff @(posedge clk) begin
        if (rst)
          digit_reg[gi] <= 5'h00;
        else if (wr_en && (int'(wr_idx) == gi))
          digit_reg[gi] <= wr_data;
      end
    end
  endgenerate

  // Candidate pointers: lowest enabled, first enabled >= ptr, first enabled > ptr.
  logic [PW-1:0] lowest_idx, first_ge_idx, next_gt_idx;
  logic          has_ge, has_gt;

  always_comb begin
    lowest_idx   = '0;
    first_ge_idx = '0;
    next_gt_idx  = '0;
    has_ge       = 1'b0;
    has_gt       = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (digit_en[i]) begin
        lowest_idx = PW'(i);
        if (i >= int'(ptr_reg)) begin
          first_ge_idx = PW'(i);
          has_ge       = 1'b1;
        end
        if (i > int'(ptr_reg)) begin
          next_gt_idx = PW'(i);
          has_gt      = 1'b1;
        end
      end
    end
  end

  logic [PW-1:0] show_ptr, after_ptr;
  logic          any_en;

  assign any_en    = |digit_en;
  assign show_ptr  = has_ge ? first_ge_idx : lowest_idx;
  assign after_ptr = has_gt ? next_gt_idx  : lowest_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= BLANK;
      cnt_reg        <= '0;
      ptr_reg        <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (state_reg == SHOW) begin
        if (cnt_reg == SHOW_LAST) begin
          state_reg      <= BLANK;
          cnt_reg        <= '0;
          ptr_reg        <= after_ptr;
          frame_done_reg <= any_en && (after_ptr <= ptr_reg);
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        if (cnt_reg == BLANK_LAST) begin
          cnt_reg <= '0;
          if (any_en) begin
            state_reg <= SHOW;
            ptr_reg   <= show_ptr;
          end else begin
            ptr_reg <= '0;
          end
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  // Output stage follows the scan state one cycle behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_reg <= 8'hFF;
      an_reg  <= '1;
    end else if (state_reg == SHOW) begin
      seg_reg         <= ~enc(digit_reg[ptr_reg]);
      an_reg          <= '1;
      an_reg[ptr_reg] <= 1'b0;
    end else begin
      seg_reg <= 8'hFF;
      an_reg  <= '1;
    end
  end

  assign seg_out    = seg_reg;
  assign an_out     = an_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus random writes,
// masks and resets, compared every cycle against a visit-level reference model.
module tb_seg_scan_ctrl;

  localparam int N  = 4;
  localparam int DV = 4;
  localparam int BK = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [2:0]   wr_idx;
  logic [4:0]   wr_data;
  logic [N-1:0] digit_en;
  logic [7:0]   seg_out;
  logic [N-1:0] an_out;
  logic         frame_done;

  seg_scan_ctrl #(.NUM_DIGITS(N), .DIV(DV), .BLANK_CYCLES(BK)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .digit_en(digit_en), .seg_out(seg_out), .an_out(an_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] enc_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                              8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  // Reference model: which digit is on (or gap), cycles left in that phase, stored values.
  bit         m_lit;
  int         m_pos;
  int         m_left;
  logic [4:0] m_dig [N];
  logic [7:0] e_seg;
  logic [N-1:0] e_an;
  logic       e_fd;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int np;
    if (rst) begin
      m_lit = 0; m_pos = 0; m_left = BK;
      for (int i = 0; i < N; i++) m_dig[i] = 5'h00;
      e_seg = 8'hFF; e_an = '1; e_fd = 0;
      return;
    end
    e_fd = 0;
    if (m_lit) begin
      e_seg = ~(enc_tab[m_dig[m_pos][3:0]] | {7'b0, m_dig[m_pos][4]});
      e_an  = ~(N'(1) << m_pos);
    end else begin
      e_seg = 8'hFF;
      e_an  = '1;
    end
    m_left--;
    if (m_left == 0) begin
      if (m_lit) begin
        np = -1;
        for (int k = 1; k <= N; k++)
          if (np < 0 && digit_en[(m_pos + k) % N]) np = (m_pos + k) % N;
        if (np >= 0) begin
          e_fd  = (np <= m_pos);
          m_pos = np;
        end else begin
          m_pos = 0;
        end
        m_lit = 0; m_left = BK;
      end else if (digit_en == 0) begin
        m_pos = 0; m_left = BK;
      end else begin
        np = -1;
        for (int k = 0; k < N; k++)
          if (np < 0 && digit_en[(m_pos + k) % N]) np = (m_pos + k) % N;
        m_pos = np; m_lit = 1; m_left = DV;
      end
    end
    if (wr_en && int'(wr_idx) < N) m_dig[wr_idx] = wr_data;
  endtask

  int fd_count;

  // One clock: model follows the edge, DUT is compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("seg", seg_out, e_seg);
    check("an", {4'b0, an_out}, {4'b0, e_an});
    check("fd", {7'b0, frame_done}, {7'b0, e_fd});
    if (frame_done) fd_count++;
  endtask

  task automatic write(input logic [2:0] idx, input logic [4:0] data);
    wr_en = 1; wr_idx = idx; wr_data = data;
    cycle();
    wr_en = 0;
  endtask

  initial begin
    rst = 1; wr_en = 0; wr_idx = 0; wr_data = 0; digit_en = 4'hF;
    e_seg = 8'hFF; e_an = '1; e_fd = 0;
    m_lit = 0; m_pos = 0; m_left = BK;
    @(negedge clk);

    // 1: reset, release, first digit after one blank cycle
    for (int i = 0; i < 3; i++) cycle();
    check("rst_seg", seg_out, 8'hFF);
    check("rst_an", {4'b0, an_out}, 8'h0F);
    rst = 0;
    cycle();
    check("post_rst_an", {4'b0, an_out}, 8'h0F);
    cycle();
    check("first_an", {4'b0, an_out}, 8'h0E);
    check("first_seg", seg_out, 8'h03);
    for (int i = 0; i < 3; i++) cycle();
    check("first_hold_an", {4'b0, an_out}, 8'h0E);

    // 2: full mask, four digits
    write(3'd0, 5'h01);
    write(3'd1, 5'h02);
    write(3'd2, 5'h03);
    write(3'd3, 5'h18);
    for (int i = 0; i < 20; i++) cycle();
    fd_count = 0;
    for (int i = 0; i < 40; i++) cycle();
    check("fd_per_40", 8'(fd_count), 8'd2);

    // 3: digits 1 and 3 only
    digit_en = 4'b1010;
    for (int i = 0; i < 40; i++) cycle();

    // 4: empty mask, then a single digit
    digit_en = 4'b0000;
    for (int i = 0; i < 8; i++) cycle();
    fd_count = 0;
    for (int i = 0; i < 20; i++) cycle();
    check("idle_fd", 8'(fd_count), 8'd0);
    check("idle_an", {4'b0, an_out}, 8'h0F);
    digit_en = 4'b0100;
    cycle();
    cycle();
    check("wake_an", {4'b0, an_out}, 8'h0B);

    // 5: rewrite the lit digit, plus an out-of-range write
    write(3'd2, 5'h0A);
    cycle();
    check("live_seg", seg_out, 8'h11);
    write(3'd5, 5'h1F);
    for (int i = 0; i < 12; i++) cycle();

    // 6: reset mid-SHOW with a concurrent write
    digit_en = 4'hF;
    begin
      int n = 0;
      while (an_out != 4'hE && n < 40) begin cycle(); n++; end
      check("wait_d0", {4'b0, an_out}, 8'h0E);
    end
    rst = 1; wr_en = 1; wr_idx = 3'd0; wr_data = 5'h07;
    cycle();
    rst = 0; wr_en = 0;
    check("rst_mid_seg", seg_out, 8'hFF);
    check("rst_mid_an", {4'b0, an_out}, 8'h0F);
    cycle();
    cycle();
    check("restart_seg", seg_out, 8'h03);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_idx  = 3'($urandom_range(0, 7));
      wr_data = 5'($urandom);
      if ($urandom_range(0, 39) == 0) digit_en = 4'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 0; wr_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
